// File: rtl/lfsr_delay_timer.sv
// LFSR-paced interval timer: a Galois LFSR walks SEED->TERM to form one base tick, a counter turns ticks into an N-tick delay.
// All outputs registered; first tick P+1 enabled cycles after start; enable low stalls everything, abort cancels without done.
module lfsr_delay_timer #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h002D,
  parameter logic [WIDTH-1:0] SEED  = '1,
  parameter logic [WIDTH-1:0] TERM  = 16'hDB6C,
  parameter int unsigned      CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] count,
  input  logic             enable,
  input  logic             abort,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] lfsr_step;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_lat_q, cnt_lat_d;
  logic             mode_lat_q, mode_lat_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  assign lfsr_step = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? POLY : '0);

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    rem_d      = rem_q;
    cnt_lat_d  = cnt_lat_q;
    mode_lat_d = mode_lat_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;

    // Priority: abort, then start (discarding any same-cycle terminal match), then normal advance.
    if (abort) begin
      if (state_q == RUN) begin
        state_d = IDLE;
        rem_d   = '0;
        lfsr_d  = SEED;
      end
    end else if (start) begin
      lfsr_d = SEED;
      if (count != '0) begin
        state_d    = RUN;
        cnt_lat_d  = count;
        rem_d      = count;
        mode_lat_d = mode;
      end else begin
        state_d = IDLE;
        rem_d   = '0;
        done_d  = 1'b1;
      end
    end else if (state_q == RUN && enable) begin
      if (lfsr_q == TERM) begin
        lfsr_d = SEED;
        tick_d = 1'b1;
        rem_d  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          done_d = 1'b1;
          // Periodic reload keeps tick spacing unbroken across the done boundary.
          if (mode_lat_q) begin
            rem_d = cnt_lat_q;
          end else begin
            state_d = IDLE;
            rem_d   = '0;
          end
        end
      end else begin
        lfsr_d = lfsr_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      rem_q      <= '0;
      cnt_lat_q  <= '0;
      mode_lat_q <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      rem_q      <= rem_d;
      cnt_lat_q  <= cnt_lat_d;
      mode_lat_q <= mode_lat_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
    end
  end

  assign tick      = tick_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);
  assign remaining = rem_q;

endmodule

// File: tb/tb_lfsr_delay_timer.sv
// Directed bench: a 4-bit configuration (F->D->9->1, P=3) for cycle-exact checks, default config for reset and period.
module tb_lfsr_delay_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, start4, mode4, enable4, abort4, tick4, done4, busy4;
  logic [9:0] count4, rem4;
  logic       rst16, start16, mode16, enable16, abort16, tick16, done16, busy16;
  logic [9:0] count16, rem16;

  int n_total = 0;
  int n_pass  = 0;

  lfsr_delay_timer #(
    .WIDTH(4), .POLY(4'h3), .SEED(4'hF), .TERM(4'h1), .CNT_W(10)
  ) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .mode(mode4), .count(count4),
    .enable(enable4), .abort(abort4), .tick(tick4), .done(done4),
    .busy(busy4), .remaining(rem4)
  );

  lfsr_delay_timer u_dut16 (
    .clk(clk), .rst(rst16), .start(start16), .mode(mode16), .count(count16),
    .enable(enable16), .abort(abort16), .tick(tick16), .done(done16),
    .busy(busy16), .remaining(rem16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Steps from SEED to TERM for the default 16-bit configuration.
  function automatic int lfsr16_steps();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int i = 0; i < 70000; i++) begin
      if (s == 16'hDB6C) return i;
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000);
    end
    return -1;
  endfunction

  initial begin
    int cyc;
    int exp_period;

    rst4 = 1'b0; start4 = 1'b0; mode4 = 1'b0; count4 = '0; enable4 = 1'b1; abort4 = 1'b0;
    rst16 = 1'b0; start16 = 1'b0; mode16 = 1'b0; count16 = '0; enable16 = 1'b1; abort16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tick4", tick4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_rem4", rem4, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_rem16", rem16, 0);
    rst4 = 1'b1; rst16 = 1'b1;
    @(negedge clk);

    // One-shot, count=3: ticks at edges 4, 8, 12; done and busy drop at 12.
    start4 = 1'b1; count4 = 10'd3; mode4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    chk("t1_busy_start", busy4, 1);
    chk("t1_rem_start", rem4, 3);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("t1_tick", tick4, (k % 4 == 0));
      chk("t1_done", done4, (k == 12));
      chk("t1_busy", busy4, (k < 12));
      chk("t1_rem", rem4, 3 - k / 4);
    end

    // Periodic, count=2: done every 8 edges, busy held, remaining reloads.
    start4 = 1'b1; count4 = 10'd2; mode4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    chk("t2_busy_start", busy4, 1);
    chk("t2_rem_start", rem4, 2);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk("t2_tick", tick4, (k % 4 == 0));
      chk("t2_done", done4, (k % 8 == 0));
      chk("t2_busy", busy4, 1);
      chk("t2_rem", rem4, 2 - ((k / 4) % 2));
    end
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    chk("t2_abort_busy", busy4, 0);
    chk("t2_abort_rem", rem4, 0);
    chk("t2_abort_done", done4, 0);

    // One-shot, count=1, enable low across edges 3..7: tick and done at edge 9.
    start4 = 1'b1; count4 = 10'd1; mode4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("t3_tick", tick4, (k == 9));
      chk("t3_done", done4, (k == 9));
      chk("t3_busy", busy4, (k < 9));
      if (k == 2) enable4 = 1'b0;
      if (k == 7) enable4 = 1'b1;
    end

    // Abort at edge 6 of a count=3 run, then a zero-count start.
    start4 = 1'b1; count4 = 10'd3; mode4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t4_tick", tick4, (k == 4));
      chk("t4_done", done4, 0);
      chk("t4_busy", busy4, (k < 6));
      chk("t4_rem", rem4, (k < 4) ? 3 : ((k < 6) ? 2 : 0));
      if (k == 5) abort4 = 1'b1;
      if (k == 6) abort4 = 1'b0;
    end
    start4 = 1'b1; count4 = 10'd0;
    @(negedge clk);
    start4 = 1'b0;
    chk("t4_zero_done", done4, 1);
    chk("t4_zero_busy", busy4, 0);
    chk("t4_zero_rem", rem4, 0);
    @(negedge clk);
    chk("t4_zero_done_clr", done4, 0);
    chk("t4_zero_busy_after", busy4, 0);

    // Restart at edge 4 discards that terminal match; first tick moves to edge 8.
    start4 = 1'b1; count4 = 10'd3; mode4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t5_tick", tick4, (k == 8));
      chk("t5_done", done4, 0);
      chk("t5_busy", busy4, 1);
      chk("t5_rem", rem4, (k < 8) ? 3 : 2);
      if (k == 3) start4 = 1'b1;
      if (k == 4) start4 = 1'b0;
    end
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;

    // Default config: async reset mid-run, then measure the base tick period.
    start16 = 1'b1; count16 = 10'd2; mode16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_busy_run", busy16, 1);
    chk("t6_rem_run", rem16, 2);
    #1 rst16 = 1'b0;
    #1;
    chk("t6_rst_tick", tick16, 0);
    chk("t6_rst_done", done16, 0);
    chk("t6_rst_busy", busy16, 0);
    chk("t6_rst_rem", rem16, 0);
    @(negedge clk);
    rst16 = 1'b1;
    @(negedge clk);
    chk("t6_post_rst_done", done16, 0);

    exp_period = lfsr16_steps() + 1;
    start16 = 1'b1; count16 = 10'd1; mode16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick16 && cyc < 70000);
    chk("t6_period", cyc, exp_period);
    chk("t6_done", done16, 1);
    chk("t6_busy_end", busy16, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lfsr_delay_timer.md
# lfsr_delay_timer

Parametrised LFSR interval timer: the next generation of the game's fixed 16-bit millisecond LFSR timer. An LFSR with parametrised width, polynomial, seed and terminal state produces a base tick, and a programmable tick counter turns that into an N-tick delay. The delay runs in one-shot or periodic mode with start/abort control. It drives sequence-display durations and player-response timeouts in the memory game controller.

## Interface
- WIDTH, 16: LFSR width in bits.
- POLY, 16'h002D: Galois feedback mask, XORed in when the shifted-out MSB is 1. Bit 0 must be set.
- SEED, all ones: LFSR load value. Must be nonzero.
- TERM, 16'hDB6C: terminal LFSR state that marks one base tick.
- CNT_W, 10: width of the tick counter.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request that latches count and mode and (re)starts the timer.
- mode  in  1  0 = one-shot, 1 = periodic. Sampled only with start.
- count  in  CNT_W  number of base ticks per delay. Sampled only with start.
- enable  in  1  advance gate. Low freezes the LFSR and the counter.
- abort  in  1  cancel the running delay.
- tick  out  1  one-cycle pulse per base tick while running.
- done  out  1  one-cycle pulse when a delay completes.
- busy  out  1  high while in RUN.
- remaining  out  CNT_W  ticks left in the current delay.

## Operation
- States: IDLE and RUN. Internal registers: lfsr[WIDTH], rem[CNT_W], cnt_lat[CNT_W], mode_lat.
- LFSR step: lfsr <= {lfsr[WIDTH-2:0],1'b0} ^ (lfsr[WIDTH-1] ? POLY : 0).
- IDLE, start=1, count≠0: cnt_lat <= count, rem <= count, mode_lat <= mode, lfsr <= SEED, go to RUN.
- IDLE, start=1, count=0: done pulses next cycle; stay IDLE; busy stays 0.
- RUN, enable=1, lfsr≠TERM: step the LFSR.
- RUN, enable=1, lfsr==TERM:
  - lfsr <= SEED, tick <= 1, rem <= rem−1.
  - If rem==1, done <= 1. Then:
    - mode_lat=1: rem <= cnt_lat, stay in RUN.
    - mode_lat=0: go to IDLE, rem <= 0.
- RUN, enable=0: all state holds; tick and done stay 0.
- RUN, start=1: restart exactly as from IDLE. Any pending terminal match that cycle is discarded, so no tick or done is issued.
- abort=1: go to IDLE, rem <= 0, lfsr <= SEED, no done. abort beats start and beats a terminal match in the same cycle. abort in IDLE has no effect.
- Base tick period = P+1 enabled cycles, where P is the number of LFSR steps from SEED to TERM. If TERM==SEED, the period is 1. TERM must lie on SEED's orbit; otherwise no tick ever occurs, and that is legal but unsupported.
- remaining = rem. It is 0 in IDLE.

## Timing
- Reset values: lfsr=SEED, state IDLE, tick=0, done=0, busy=0, remaining=0, cnt_lat=0, mode_lat=0.
- All outputs are registered.
- busy rises on the clock edge that samples start and falls on the edge that issues the final one-shot done, or on the abort edge.
- tick and done are asserted for exactly one cycle and are coincident on the final tick.
- Latency: with enable held high, the k-th tick appears k·(P+1) edges after the start-sampling edge.
- Periodic mode reloads with zero gap: tick spacing stays P+1 across the done boundary.
- Asynchronous reset mid-delay: all outputs clear immediately; no done is issued.

## Test plan
- Config WIDTH=4, POLY=4'h3, SEED=4'hF, TERM=4'h1 (path F→D→9→1, P=3). One-shot, count=3, enable held high → tick on edges 4, 8, 12 after start; done with tick at edge 12; busy drops at edge 12; remaining reads 3,2,1,0.
- Same config, periodic, count=2 → done at edges 8, 16, 24; busy stays 1; remaining reloads to 2 after each done.
- Same config, one-shot, count=1, enable low for 5 cycles after edge 2 → tick and done at edge 9.
- Same config, abort at edge 6 of a count=3 run → busy 0 at edge 6, no done, remaining=0. Then start with count=0 → done next edge, busy stays 0.
- Same config, start re-asserted at edge 4 of a running delay → no tick at edge 4; first tick at edge 8.
- Default parameters, rst pulled low mid-run → tick=done=busy=0 and remaining=0 immediately. One-shot count=1 after release → tick period equals P+1 for SEED→16'hDB6C.
